alu_result_queue: RTL and testbench



---
 rtl/alu_result_queue.sv | 101 ++++++++++
 tb/tb_alu_result_queue.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/alu_result_queue.sv
// alu_result_queue: buffers ALU result words and their flags in a small FIFO
// for the writeback stage. It also tracks last-result status, sticky
// carry/overflow bits and a saturating count of overflow events.
module alu_result_queue #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_W-1:0]           in_z,
  input  logic                        in_sign,
  input  logic                        in_zero,
  input  logic                        in_carry,
  input  logic                        in_parity,
  input  logic                        in_overflow,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           out_z,
  output logic [4:0]                  out_flags,
  output logic [4:0]                  status_flags,
  output logic                        sticky_carry,
  output logic                        sticky_ovf,
  output logic [7:0]                  ovf_count,
  input  logic                        clr_sticky,
  output logic [$clog2(DEPTH):0]      level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [DATA_W-1:0] z;
    logic [4:0]        flags;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [4:0]      in_flags;
  logic            push, pop;

  // Handshake is derived from the registered level only, so no
  // combinational path exists from in_valid/out_ready to the ready/valid outs.
  assign in_flags  = {in_overflow, in_parity, in_carry, in_zero, in_sign};
  assign in_ready  = (level != FULL_LVL);
  assign out_valid = (level != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_z     = mem[rd_ptr].z;
  assign out_flags = mem[rd_ptr].flags;

  // Storage write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{z: in_z, flags: in_flags};
  end

  // Pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Status path follows pushes only; a push in the same cycle as a clear
  // overrides the clear with the pushed flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_flags <= '0;
      sticky_carry <= 1'b0;
      sticky_ovf   <= 1'b0;
      ovf_count    <= '0;
    end else if (push) begin
      status_flags <= in_flags;
      if (clr_sticky) begin
        sticky_carry <= in_carry;
        sticky_ovf   <= in_overflow;
        ovf_count    <= {7'd0, in_overflow};
      end else begin
        sticky_carry <= sticky_carry | in_carry;
        sticky_ovf   <= sticky_ovf | in_overflow;
        if (in_overflow && ovf_count != 8'hFF) ovf_count <= ovf_count + 1'b1;
      end
    end else if (clr_sticky) begin
      sticky_carry <= 1'b0;
      sticky_ovf   <= 1'b0;
      ovf_count    <= '0;
    end
  end

endmodule

// File: tb/tb_alu_result_queue.sv
// Randomized + directed bench for alu_result_queue against a queue-based model.
module tb_alu_result_queue;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid, out_ready, clr_sticky;
  logic [DATA_W-1:0] in_z;
  logic [4:0]        fl;
  logic              in_ready, out_valid, sticky_carry, sticky_ovf;
  logic [DATA_W-1:0] out_z;
  logic [4:0]        out_flags, status_flags;
  logic [7:0]        ovf_count;
  logic [2:0]        level;

  alu_result_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_z(in_z),
    .in_sign(fl[0]), .in_zero(fl[1]), .in_carry(fl[2]),
    .in_parity(fl[3]), .in_overflow(fl[4]),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_z(out_z), .out_flags(out_flags),
    .status_flags(status_flags), .sticky_carry(sticky_carry),
    .sticky_ovf(sticky_ovf), .ovf_count(ovf_count),
    .clr_sticky(clr_sticky), .level(level)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [20:0] mq[$];
  logic [4:0]  m_stat;
  logic        m_sc, m_so;
  int          m_cnt;
  int          n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    mq.delete();
    m_stat = '0; m_sc = 1'b0; m_so = 1'b0; m_cnt = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".level"}, 32'(level), 32'(mq.size()));
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(mq.size() < DEPTH));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(mq.size() > 0));
    if (mq.size() > 0) begin
      chk({tag, ".out_z"}, 32'(out_z), 32'(mq[0][20:5]));
      chk({tag, ".out_flags"}, 32'(out_flags), 32'(mq[0][4:0]));
    end
    chk({tag, ".status"}, 32'(status_flags), 32'(m_stat));
    chk({tag, ".sc"}, 32'(sticky_carry), 32'(m_sc));
    chk({tag, ".so"}, 32'(sticky_ovf), 32'(m_so));
    chk({tag, ".cnt"}, 32'(ovf_count), 32'(m_cnt));
  endtask

  // One clock: drive at negedge, model the edge, check at next negedge.
  task automatic cyc(input string tag, input logic v, input logic [15:0] z,
                     input logic [4:0] f, input logic ordy, input logic clr);
    bit push, pop;
    in_valid = v; in_z = z; fl = f; out_ready = ordy; clr_sticky = clr;
    push = v && (mq.size() < DEPTH);
    pop  = ordy && (mq.size() > 0);
    @(posedge clk);
    if (pop)  void'(mq.pop_front());
    if (push) begin
      mq.push_back({z, f});
      m_stat = f;
      m_sc = clr ? f[2] : (m_sc | f[2]);
      m_so = clr ? f[4] : (m_so | f[4]);
      if (clr) m_cnt = f[4];
      else if (f[4]) m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
    end else if (clr) begin
      m_sc = 1'b0; m_so = 1'b0; m_cnt = 0;
    end
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    in_valid = 0; out_ready = 0; clr_sticky = 0; in_z = '0; fl = '0;
    rst_n = 1'b0;
    model_reset();
    #1 check_all("reset");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Single push with sign and overflow
    cyc("single", 1, 16'h8000, 5'b10001, 0, 0);
    chk("single.out_flags_k", 32'(out_flags), 32'h11);
    chk("single.cnt_k", 32'(ovf_count), 32'd1);
    cyc("single_pop", 0, 16'h0, 5'b0, 1, 0);

    // Fill, refused 5th push, drain in order
    for (int i = 1; i <= 4; i++) cyc("fill", 1, 16'(i), 5'(i), 0, 0);
    chk("fill.in_ready_k", 32'(in_ready), 32'd0);
    cyc("fill5", 1, 16'h0005, 5'b0, 0, 0);
    chk("fill5.level_k", 32'(level), 32'd4);
    for (int i = 1; i <= 4; i++) begin
      chk("drain.z_k", 32'(out_z), 32'(i));
      cyc("drain", 0, 16'h0, 5'b0, 1, 0);
    end
    chk("drain.level_k", 32'(level), 32'd0);

    // Full with simultaneous push/pop, then steady push+pop across wrap
    for (int i = 0; i < 4; i++) cyc("fill2", 1, 16'h0100 + 16'(i), 5'b0, 0, 0);
    cyc("fullpp", 1, 16'h0200, 5'b0, 1, 0);
    chk("fullpp.level_k", 32'(level), 32'd3);
    cyc("pp", 1, 16'h0201, 5'b0, 1, 0);
    chk("pp.level_k", 32'(level), 32'd3);
    for (int i = 0; i < 4; i++) cyc("wrapdrain", 0, 16'h0, 5'b0, 1, 0);

    // Saturation of the overflow counter, then a lone clear
    for (int i = 0; i < 260; i++) cyc("sat", 1, 16'(i), 5'b10000, 1, 0);
    chk("sat.cnt_k", 32'(ovf_count), 32'd255);
    cyc("clr", 0, 16'h0, 5'b0, 1, 1);
    chk("clr.cnt_k", 32'(ovf_count), 32'd0);
    chk("clr.status_k", 32'(status_flags), 32'h10);

    // Clear colliding with a push
    cyc("clrcol", 1, 16'h1234, 5'b10100, 0, 1);
    chk("clrcol.cnt_k", 32'(ovf_count), 32'd1);
    chk("clrcol.sc_k", 32'(sticky_carry), 32'd1);

    // Randomized traffic
    for (int i = 0; i < 400; i++)
      cyc("rand", ($urandom_range(0, 3) != 0), 16'($urandom), 5'($urandom),
          ($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0));

    // Async reset mid-stream at level 2
    while (mq.size() != 0) cyc("pre_rst", 0, 16'h0, 5'b0, 1, 0);
    cyc("pre_rst2", 1, 16'h1111, 5'b00111, 0, 0);
    cyc("pre_rst2", 1, 16'h2222, 5'b10100, 0, 0);
    chk("pre_rst.level_k", 32'(level), 32'd2);
    in_valid = 1; out_ready = 1; clr_sticky = 0;
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all("async_rst");
    chk("async_rst.level_k", 32'(level), 32'd0);
    in_valid = 0; out_ready = 0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc("post_rst", 1, 16'hA5A5, 5'b0, 0, 0);
    chk("post_rst.z_k", 32'(out_z), 32'hA5A5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
